// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertically aligned
// 3-pixel columns (rows r-2, r-1, r) behind a valid/ack handshake.
module line_buffer_3row #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int COL_W      = 9,
    parameter int ROW_W      = 9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_pixel,
    input  logic       i_pixel_valid,
    output logic       o_pixel_ack,
    output logic [7:0] o_pixel_1,
    output logic [7:0] o_pixel_2,
    output logic [7:0] o_pixel_3,
    output logic       o_pixel_valid,
    input  logic       i_pixel_ack,
    output logic       o_col_last
);

    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic             vld_q, vld_d;
    logic [7:0]       pix1_q, pix1_d;
    logic [7:0]       pix2_q, pix2_d;
    logic [7:0]       pix3_q, pix3_d;
    logic             last_q, last_d;

    // LA holds row r-1, LB holds row r-2; contents are never reset.
    logic [7:0]       la_mem [IMG_WIDTH];
    logic [7:0]       lb_mem [IMG_WIDTH];
    logic [7:0]       la_rd, lb_rd;

    logic acc;
    logic col_end;
    logic row_end;

    assign o_pixel_ack = !vld_q || i_pixel_ack;
    assign acc         = i_pixel_valid && o_pixel_ack;
    assign col_end     = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_end     = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign la_rd       = la_mem[col_q];
    assign lb_rd       = lb_mem[col_q];

    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb_mem[col_q] <= la_rd;
            la_mem[col_q] <= i_pixel;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (acc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
                case (state_q)
                    PRIME0:  state_d = PRIME1;
                    PRIME1:  state_d = STREAM;
                    STREAM: begin
                        if (row_end) begin
                            state_d = PRIME0;
                            row_d   = '0;
                        end
                    end
                    default: state_d = PRIME0;
                endcase
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // A STREAM accept reloads the output register even while it is being taken,
    // so back-to-back columns never leave a bubble.
    always_comb begin
        vld_d  = vld_q;
        pix1_d = pix1_q;
        pix2_d = pix2_q;
        pix3_d = pix3_q;
        last_d = last_q;
        if (acc && (state_q == STREAM)) begin
            vld_d  = 1'b1;
            pix1_d = lb_rd;
            pix2_d = la_rd;
            pix3_d = i_pixel;
            last_d = col_end;
        end else if (vld_q && i_pixel_ack) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= PRIME0;
            col_q   <= '0;
            row_q   <= '0;
            vld_q   <= 1'b0;
            pix1_q  <= '0;
            pix2_q  <= '0;
            pix3_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vld_q   <= vld_d;
            pix1_q  <= pix1_d;
            pix2_q  <= pix2_d;
            pix3_q  <= pix3_d;
            last_q  <= last_d;
        end
    end

    assign o_pixel_valid = vld_q;
    assign o_pixel_1     = pix1_q;
    assign o_pixel_2     = pix2_q;
    assign o_pixel_3     = pix3_q;
    assign o_col_last    = last_q;

endmodule
